spi_slave_fifo: RTL and testbench
=================================

// Module: spi_slave_fifo
// PURPOSE
//  Parametrised SPI slave for the analyzer host link: any CPOL/CPHA mode, DW-bit words, MSB first.
//  Samples raw SPI pins in the clk domain; RX/TX words pass through internal synchronous FIFOs.
//  Valid/ready stream ports face the command decoder and the transmit path.
//  Flags overflow/underflow instead of silently corrupting data.
// PARAMETERS
//  DW        8   word width in bits (4..32)
//  RX_AW     4   log2 RX FIFO depth (depth 16)
//  TX_AW     4   log2 TX FIFO depth (depth 16)
//  CPOL      0   SCLK idle level
//  CPHA      0   0: sample on leading edge; 1: sample on trailing edge
//  IDLE_WORD 0   word shifted out on MISO when the TX FIFO is empty
// PORTS
//  clk        in   1        system clock; must be >= 8x SCLK frequency
//  rst_n      in   1        asynchronous active-low reset
//  spi_cs_n   in   1        raw chip select, active low
//  spi_sclk   in   1        raw SPI clock
//  spi_mosi   in   1        raw master-out data
//  spi_miso   out  1        slave-out data; 0 while CS inactive
//  tx_data    in   DW       word to send
//  tx_valid   in   1        tx_data valid
//  tx_ready   out  1        TX FIFO not full
//  rx_data    out  DW       received word (FIFO head)
//  rx_valid   out  1        RX FIFO not empty
//  rx_ready   in   1        consumer pops head when rx_valid & rx_ready
//  rx_level   out  RX_AW+1  RX FIFO occupancy
//  tx_level   out  TX_AW+1  TX FIFO occupancy
//  busy       out  1        frame in progress (synchronised CS low)
//  rx_ovf     out  1        1-clk pulse: received word dropped, RX FIFO full
//  tx_udf     out  1        1-clk pulse: IDLE_WORD loaded, TX FIFO empty
// BEHAVIOUR
//  Reset: both FIFOs empty, shifters/bit counter 0, FSM IDLE; spi_miso=0, tx_ready=1, rx_valid=0,
//   levels=0, busy=0, rx_ovf=0, tx_udf=0.
//  Inputs: 2-flop synchronisers on cs_n/sclk/mosi; third flop on sclk for edge detect.
//  Sample edge = rising if CPOL^CPHA==0, else falling; the other edge is the shift edge.
//  FSM IDLE->LOAD on synced CS fall: pop TX FIFO (or IDLE_WORD + tx_udf) into tx shifter;
//   bit_cnt=0; LOAD->ACTIVE next clk; MISO=tx shifter MSB from ACTIVE entry.
//  ACTIVE: sample edge shifts mosi into rx shifter LSB, bit_cnt+1; shift edge shifts tx
//   shifter left. CPHA=1: the first shift edge of a frame does not shift.
//  bit_cnt==DW-1 at a sample edge: push word to RX FIFO (or drop + rx_ovf if full);
//   bit_cnt wraps to 0; next tx word loaded at that same clk, as in LOAD.
//  rx_valid rises <=4 clk after the raw final sample edge.
//  Any state -> IDLE on synced CS rise: partial word discarded (no push, no flag); spi_miso=0.
//  FIFOs: push+pop in the same clk while full (RX) or empty (TX) are both honoured;
//   level unchanged. Pointers are RX_AW+1 / TX_AW+1 bits with wrap bit.
//  tx_valid while !tx_ready: word ignored, no flag. tx_level counts words not yet loaded.
//  Async reset mid-frame: all state cleared immediately; resumes at next CS fall.
// CONFIGURATION
//  SPI_SLAVE_ERRCNT_EN defined: adds outputs ovf_cnt[7:0] and udf_cnt[7:0].
//   Each counts its flag pulses, saturates at 255; cleared only by rst_n.
//  Undefined: ports absent, no counter logic.
// TESTING
//  Mode 0, DW=8: master sends 0xA5 while TX holds 0x3C -> rx_data=0xA5, master reads 0x3C.
//  All 4 modes, DW=16: send 0x1234/0xBEEF back-to-back -> two RX words in order; MISO sequence matches.
//  TX FIFO empty, IDLE_WORD=0xFF -> master reads 0xFF; tx_udf pulses once per word.
//  rx_ready=0, 17 words sent -> 16 stored, rx_level=16; 17th gives one rx_ovf pulse; head=word 1.
//  CS raised after 5 bits, then full 0x81 frame -> only 0x81 received; rx_level=1.
//  rst_n pulsed mid-frame -> all outputs at reset values; next frame received correctly.

Source files
------------

// File: rtl/spi_slave_fifo_if.sv
// rtl/spi_slave_fifo_if.sv - RX/TX word streams between the SPI slave and its host logic
interface spi_slave_fifo_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - SPI slave (any CPOL/CPHA, MSB first) with RX/TX word FIFOs
// Optional SPI_SLAVE_ERRCNT_EN adds saturating overflow/underflow counters.
module spi_slave_fifo #(
    parameter int            DW        = 8,
    parameter int            RX_AW     = 4,
    parameter int            TX_AW     = 4,
    parameter int            CPOL      = 0,
    parameter int            CPHA      = 0,
    parameter logic [DW-1:0] IDLE_WORD = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_cs_n,
    input  logic               spi_sclk,
    input  logic               spi_mosi,
    output logic               spi_miso,
    spi_slave_fifo_if.slave    bus,
    output logic [RX_AW:0]     rx_level,
    output logic [TX_AW:0]     tx_level,
    output logic               busy,
    output logic               rx_ovf,
    output logic               tx_udf
`ifdef SPI_SLAVE_ERRCNT_EN
    ,
    output logic [7:0]         ovf_cnt,
    output logic [7:0]         udf_cnt
`endif
);
    localparam int   CW             = $clog2(DW);
    localparam logic SCLK_IDLE      = (CPOL != 0);
    localparam logic SAMPLE_ON_RISE = ((CPOL != 0) == (CPHA != 0));

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [2:0]    cs_q;
    logic [2:0]    sclk_q;
    logic [1:0]    mosi_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-2:0] rx_shift_q, rx_shift_d;
    logic [DW-1:0] tx_shift_q, tx_shift_d;
    logic          skip_q, skip_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          tx_udf_q, tx_udf_d;

    logic          sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic          cs_fall, cs_high;
    logic          load, frame_start;
    logic [DW-1:0] rx_word, tx_word;

    logic [DW-1:0]  rx_mem_q [2**RX_AW];
    logic [RX_AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic           rx_push, rx_pop, rx_wr, rx_full, rx_empty;

    logic [DW-1:0]  tx_mem_q [2**TX_AW];
    logic [TX_AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic           tx_push, tx_rd, tx_full, tx_empty;

    // CS sync chain resets low so a CS already held low at reset release is not seen as a new fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 3'b000;
            sclk_q <= {3{SCLK_IDLE}};
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs_n};
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign cs_fall     = cs_q[2] & ~cs_q[1];
    assign cs_high     = cs_q[1];

    assign rx_word = {rx_shift_q, mosi_q[1]};

    // A freshly loaded word must survive the next shift edge, except in CPHA=0 at frame start
    // where the first edge after the load is a sample edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        skip_d      = skip_q;
        rx_push     = 1'b0;
        load        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_LOAD;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    load        = 1'b1;
                    frame_start = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = cs_high ? ST_IDLE : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cs_high) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_word[DW-2:0];
                        if (bit_cnt_q == CW'(DW - 1)) begin
                            rx_push   = 1'b1;
                            bit_cnt_d = '0;
                            load      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            tx_shift_d = tx_word;
            skip_d     = (CPHA != 0) || !frame_start;
        end
    end

    assign rx_empty  = (rx_wptr_q == rx_rptr_q);
    assign rx_full   = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                       (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
    assign rx_pop    = bus.rx_ready && !rx_empty;
    assign rx_wr     = rx_push && (!rx_full || rx_pop);
    assign rx_wptr_d = rx_wptr_q + {{RX_AW{1'b0}}, rx_wr};
    assign rx_rptr_d = rx_rptr_q + {{RX_AW{1'b0}}, rx_pop};
    assign rx_ovf_d  = rx_push && rx_full && !rx_pop;

    // An empty TX FIFO hands a word pushed in the load cycle straight to the shifter.
    assign tx_empty  = (tx_wptr_q == tx_rptr_q);
    assign tx_full   = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                       (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    assign tx_push   = bus.tx_valid && !tx_full;
    assign tx_rd     = load && (!tx_empty || tx_push);
    assign tx_word   = !tx_empty ? tx_mem_q[tx_rptr_q[TX_AW-1:0]] :
                       (tx_push ? bus.tx_data : IDLE_WORD);
    assign tx_wptr_d = tx_wptr_q + {{TX_AW{1'b0}}, tx_push};
    assign tx_rptr_d = tx_rptr_q + {{TX_AW{1'b0}}, tx_rd};
    assign tx_udf_d  = load && tx_empty && !tx_push;

    always_ff @(posedge clk) begin
        if (rx_wr) begin
            rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_word;
        end
        if (tx_push) begin
            tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            skip_q     <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_udf_q   <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            skip_q     <= skip_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_udf_q   <= tx_udf_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
        end
    end

    assign spi_miso     = (state_q == ST_ACTIVE) ? tx_shift_q[DW-1] : 1'b0;
    assign busy         = (state_q != ST_IDLE);
    assign rx_ovf       = rx_ovf_q;
    assign tx_udf       = tx_udf_q;
    assign rx_level     = rx_wptr_q - rx_rptr_q;
    assign tx_level     = tx_wptr_q - tx_rptr_q;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_mem_q[rx_rptr_q[RX_AW-1:0]];
    assign bus.tx_ready = !tx_full;

`ifdef SPI_SLAVE_ERRCNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] udf_cnt_q, udf_cnt_d;

    assign ovf_cnt_d = (rx_ovf_q && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    assign udf_cnt_d = (tx_udf_q && udf_cnt_q != 8'hFF) ? udf_cnt_q + 8'd1 : udf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
            udf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`else
    // Error counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb/tb_spi_slave_fifo.sv - randomized bench driving all four SPI modes against a queue model
`timescale 1ns/1ps
module tb_spi_slave_fifo;
    localparam int            DW    = 8;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] IDLE  = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cs_n, sclk_base, mosi;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic [3:0]    rx_ready_a, rx_valid_a, tx_ready_a, miso_a, busy_a, rx_ovf_a, tx_udf_a;
    logic [DW-1:0] rx_data_a [4];
    logic [4:0]    rx_level_a [4];
    logic [4:0]    tx_level_a [4];
`ifdef SPI_SLAVE_ERRCNT_EN
    logic [7:0]    ovf_cnt_a [4];
    logic [7:0]    udf_cnt_a [4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int POL = g / 2;
        localparam int PHA = g % 2;
        spi_slave_fifo_if #(.DW(DW)) bus ();
        assign bus.tx_data    = tx_data;
        assign bus.tx_valid   = tx_valid;
        assign bus.rx_ready   = rx_ready_a[g];
        assign tx_ready_a[g]  = bus.tx_ready;
        assign rx_valid_a[g]  = bus.rx_valid;
        assign rx_data_a[g]   = bus.rx_data;

        spi_slave_fifo #(
            .DW(DW), .RX_AW(4), .TX_AW(4), .CPOL(POL), .CPHA(PHA), .IDLE_WORD(IDLE)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .spi_cs_n (cs_n),
            .spi_sclk (sclk_base ^ (POL != 0)),
            .spi_mosi (mosi),
            .spi_miso (miso_a[g]),
            .bus      (bus),
            .rx_level (rx_level_a[g]),
            .tx_level (tx_level_a[g]),
            .busy     (busy_a[g]),
            .rx_ovf   (rx_ovf_a[g]),
            .tx_udf   (tx_udf_a[g])
`ifdef SPI_SLAVE_ERRCNT_EN
            ,
            .ovf_cnt  (ovf_cnt_a[g]),
            .udf_cnt  (udf_cnt_a[g])
`endif
        );
    end

    int n_chk = 0;
    int n_fail = 0;
    int ovf_seen [4] = '{default: 0};
    int udf_seen [4] = '{default: 0};

    logic [DW-1:0] mrx [4][$];
    logic [DW-1:0] mtx [4][$];
    int            m_ovf [4] = '{default: 0};
    int            m_udf [4] = '{default: 0};
    int            ovf_base [4] = '{default: 0};
    int            udf_base [4] = '{default: 0};
    logic [DW-1:0] m_words [32];
    logic [DW-1:0] miso_rx [4][32];

    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_ovf_a[g] === 1'b1) ovf_seen[g] <= ovf_seen[g] + 1;
            if (tx_udf_a[g] === 1'b1) udf_seen[g] <= udf_seen[g] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] model_load(input int g);
        if (mtx[g].size() != 0) return mtx[g].pop_front();
        m_udf[g]++;
        return IDLE;
    endfunction

    task automatic check_idle(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s rx_valid m%0d", tag, g), rx_valid_a[g], 0);
            chk($sformatf("%s tx_ready m%0d", tag, g), tx_ready_a[g], 1);
            chk($sformatf("%s rx_level m%0d", tag, g), rx_level_a[g], 0);
            chk($sformatf("%s tx_level m%0d", tag, g), tx_level_a[g], 0);
            chk($sformatf("%s busy m%0d", tag, g), busy_a[g], 0);
            chk($sformatf("%s miso m%0d", tag, g), miso_a[g], 0);
            chk($sformatf("%s flags m%0d", tag, g), {rx_ovf_a[g], tx_udf_a[g]}, 0);
        end
    endtask

    task automatic post_checks(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s rx_level m%0d", tag, g), rx_level_a[g], mrx[g].size());
            chk($sformatf("%s tx_level m%0d", tag, g), tx_level_a[g], mtx[g].size());
            chk($sformatf("%s ovf m%0d", tag, g), ovf_seen[g], m_ovf[g]);
            chk($sformatf("%s udf m%0d", tag, g), udf_seen[g], m_udf[g]);
            chk($sformatf("%s busy m%0d", tag, g), busy_a[g], 0);
`ifdef SPI_SLAVE_ERRCNT_EN
            chk($sformatf("%s ovf_cnt m%0d", tag, g), ovf_cnt_a[g],
                (m_ovf[g] - ovf_base[g] > 255) ? 255 : m_ovf[g] - ovf_base[g]);
            chk($sformatf("%s udf_cnt m%0d", tag, g), udf_cnt_a[g],
                (m_udf[g] - udf_base[g] > 255) ? 255 : m_udf[g] - udf_base[g]);
`endif
        end
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("tx_ready m%0d", g), tx_ready_a[g], (mtx[g].size() < DEPTH));
            if (mtx[g].size() < DEPTH) mtx[g].push_back(w);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        for (int g = 0; g < 4; g++) begin
            mrx[g].delete();
            mtx[g].delete();
            ovf_base[g] = m_ovf[g];
            udf_base[g] = m_udf[g];
        end
        wait_clk(2);
        rst_n = 1'b1;
    endtask

    // MOSI is held across a whole SCLK period so every mode sees a stable bit at its sample edge.
    task automatic spi_frame(input int nw, input int tail, input int rst_bit);
        logic [DW-1:0] acc [4];
        int            nb;
        int            bit_idx;
        bit_idx = 0;
        cs_n = 1'b0;
        wait_clk(8);
        for (int w = 0; w < nw + ((tail > 0) ? 1 : 0); w++) begin
            nb = (w < nw) ? DW : tail;
            for (int b = 0; b < nb; b++) begin
                if (bit_idx == rst_bit) mid_reset();
                bit_idx++;
                mosi = m_words[w][DW-1-b];
                wait_clk(4);
                for (int g = 0; g < 4; g++)
                    if (g % 2 == 0) acc[g] = {acc[g][DW-2:0], miso_a[g]};
                sclk_base = 1'b1;
                wait_clk(8);
                for (int g = 0; g < 4; g++)
                    if (g % 2 == 1) acc[g] = {acc[g][DW-2:0], miso_a[g]};
                sclk_base = 1'b0;
                wait_clk(4);
            end
            if (w < nw) for (int g = 0; g < 4; g++) miso_rx[g][w] = acc[g];
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(10);
    endtask

    task automatic model_frame(input int nw);
        logic [DW-1:0] exp;
        for (int g = 0; g < 4; g++) begin
            exp = model_load(g);
            for (int k = 0; k < nw; k++) begin
                chk($sformatf("miso m%0d w%0d", g, k), miso_rx[g][k], exp);
                if (mrx[g].size() >= DEPTH) m_ovf[g]++;
                else mrx[g].push_back(m_words[k]);
                exp = model_load(g);
            end
        end
    endtask

    task automatic drain();
        logic [DW-1:0] e;
        for (int g = 0; g < 4; g++) begin
            while (mrx[g].size() != 0) begin
                e = mrx[g].pop_front();
                chk($sformatf("rx_valid m%0d", g), rx_valid_a[g], 1);
                chk($sformatf("rx_data m%0d", g), rx_data_a[g], e);
                rx_ready_a[g] = 1'b1;
                wait_clk(1);
                rx_ready_a[g] = 1'b0;
            end
            chk($sformatf("drained m%0d", g), rx_valid_a[g], 0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int npush, nw;
        rst_n = 1'b0; cs_n = 1'b1; sclk_base = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready_a = 4'b0;
        wait_clk(3);
        check_idle("reset");
        rst_n = 1'b1;
        wait_clk(6);
        check_idle("release");

        push_tx(8'h3C);
        m_words[0] = 8'hA5;
        spi_frame(1, 0, -1);
        chk("basic miso", miso_rx[0][0], 8'h3C);
        chk("basic rx", rx_data_a[0], 8'hA5);
        model_frame(1);
        post_checks("basic");
        drain();

        push_tx(8'hC3);
        push_tx(8'h5A);
        m_words[0] = 8'h12;
        m_words[1] = 8'hEF;
        spi_frame(2, 0, -1);
        model_frame(2);
        post_checks("b2b");
        drain();

        m_words[0] = 8'h69;
        m_words[1] = 8'h0F;
        spi_frame(2, 0, -1);
        chk("idle miso", miso_rx[3][1], 8'hFF);
        model_frame(2);
        post_checks("udf");
        drain();

        for (int i = 0; i < 17; i++) push_tx(DW'($urandom));
        for (int g = 0; g < 4; g++) chk($sformatf("txfull m%0d", g), tx_level_a[g], 16);
        for (int i = 0; i < 17; i++) m_words[i] = DW'($urandom);
        spi_frame(17, 0, -1);
        model_frame(17);
        post_checks("ovf");
        drain();

        m_words[0] = DW'($urandom);
        spi_frame(0, 5, -1);
        model_frame(0);
        post_checks("partial");
        m_words[0] = 8'h81;
        spi_frame(1, 0, -1);
        model_frame(1);
        post_checks("after_partial");
        drain();

        push_tx(8'h11);
        push_tx(8'h22);
        for (int g = 0; g < 4; g++) void'(model_load(g));
        m_words[0] = DW'($urandom);
        spi_frame(1, 0, 3);
        post_checks("rst_frame");
        push_tx(8'h96);
        m_words[0] = 8'h7E;
        spi_frame(1, 0, -1);
        model_frame(1);
        post_checks("after_rst");
        drain();

        for (int it = 0; it < 20; it++) begin
            npush = $urandom_range(0, 3);
            nw    = $urandom_range(1, 3);
            for (int i = 0; i < npush; i++) push_tx(DW'($urandom));
            for (int i = 0; i < nw; i++) m_words[i] = DW'($urandom);
            spi_frame(nw, 0, -1);
            model_frame(nw);
            post_checks($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
